// File: rtl/evaluate_pv_multi_pkg.sv
// Shared control-word layout, FSM state type and configuration check for the multi-PV evaluator.
package evaluate_pv_multi_pkg;

  localparam int PV_CTRL_WRITE_BIT      = 31;
  localparam int PV_CTRL_CLEAR_ALL_BIT  = 30;
  localparam int PV_CTRL_CLEAR_LINE_BIT = 29;
  localparam int PV_CTRL_LINE_MSB       = 28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } eval_state_t;

  // Move, ply and entry-valid fields must stay clear of the line-select field.
  function automatic bit ctrlFits(input int uciWidth, input int plyWidth, input int lineWidth);
    return (uciWidth + plyWidth + 1) <= (29 - lineWidth);
  endfunction

endpackage

// File: rtl/evaluate_pv_multi_line_store.sv
// One principal-variation line: a ply-indexed move array with per-ply valid bits and a
// combinational hit for the ply being matched.
module pv_line_store
  import evaluate_pv_multi_pkg::*;
#(
  parameter int UCI_WIDTH      = 16,
  parameter int MAX_DEPTH_LOG2 = 6
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_write,
  input  logic                      i_entry_valid,
  input  logic [MAX_DEPTH_LOG2-1:0] i_wr_ply,
  input  logic [UCI_WIDTH-1:0]      i_wr_move,
  input  logic                      i_clear,
  input  logic                      i_consume,
  input  logic [MAX_DEPTH_LOG2-1:0] i_consume_ply,
  input  logic [MAX_DEPTH_LOG2-1:0] i_rd_ply,
  input  logic [UCI_WIDTH-1:0]      i_rd_move,
  output logic                      o_hit
);

  localparam int MAX_DEPTH = 1 << MAX_DEPTH_LOG2;

  logic [UCI_WIDTH-1:0] r_moves [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] r_valid;
  logic [MAX_DEPTH-1:0] w_validNext;

  // Consume, then clear, then write: a later operation wins on the same bit.
  always_comb begin
    w_validNext = r_valid;
    if (i_consume) w_validNext[i_consume_ply] = 1'b0;
    if (i_clear)   w_validNext = '0;
    if (i_write)   w_validNext[i_wr_ply] = i_entry_valid;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_valid <= '0;
    else         r_valid <= w_validNext;
  end

  always_ff @(posedge i_clk) begin
    if (i_write) r_moves[i_wr_ply] <= i_wr_move;
  end

  assign o_hit = r_valid[i_rd_ply] && (r_moves[i_rd_ply] == i_rd_move);

endmodule

// File: rtl/evaluate_pv_multi.sv
// Multi-PV move matcher: flags a candidate move found in any stored PV line at the current
// ply, reports the lowest matching line and a hit mask, and paces eval_valid with a latency FSM.
module evaluate_pv_multi
  import evaluate_pv_multi_pkg::*;
#(
  parameter int UCI_WIDTH      = 16,
  parameter int MAX_DEPTH_LOG2 = 6,
  parameter int NUM_PV_LOG2    = 2,
  parameter int LATENCY_COUNT  = 2,
  parameter int AUTO_CLEAR     = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_board_valid,
  input  logic [UCI_WIDTH-1:0]      i_uci_in,
  input  logic [MAX_DEPTH_LOG2-1:0] i_pv_ply,
  input  logic                      i_clear_eval,
  input  logic [31:0]               i_pv_ctrl_in,
  output logic                      o_eval_pv_flag,
  output logic [NUM_PV_LOG2-1:0]    o_eval_pv_line,
  output logic [(1<<NUM_PV_LOG2)-1:0] o_eval_pv_mask,
  output logic                      o_eval_valid
);

  localparam int NUM_PV = 1 << NUM_PV_LOG2;
  localparam int CNT_W  = (LATENCY_COUNT > 1) ? $clog2(LATENCY_COUNT) : 1;

  if (!ctrlFits(UCI_WIDTH, MAX_DEPTH_LOG2, NUM_PV_LOG2) || LATENCY_COUNT < 1) begin : g_badConfig
    $fatal(1, "evaluate_pv_multi: control word fields overlap or LATENCY_COUNT < 1");
  end

  logic                      w_ctrlWrite;
  logic                      w_ctrlClearAll;
  logic                      w_ctrlClearLine;
  logic [NUM_PV_LOG2-1:0]    w_ctrlLine;
  logic                      w_ctrlEntryValid;
  logic [MAX_DEPTH_LOG2-1:0] w_ctrlPly;
  logic [UCI_WIDTH-1:0]      w_ctrlMove;
  logic                      w_unusedCtrl;

  assign w_ctrlWrite      = i_pv_ctrl_in[PV_CTRL_WRITE_BIT];
  assign w_ctrlClearAll   = i_pv_ctrl_in[PV_CTRL_CLEAR_ALL_BIT];
  assign w_ctrlClearLine  = i_pv_ctrl_in[PV_CTRL_CLEAR_LINE_BIT];
  assign w_ctrlLine       = i_pv_ctrl_in[PV_CTRL_LINE_MSB -: NUM_PV_LOG2];
  assign w_ctrlEntryValid = i_pv_ctrl_in[UCI_WIDTH+MAX_DEPTH_LOG2];
  assign w_ctrlPly        = i_pv_ctrl_in[UCI_WIDTH +: MAX_DEPTH_LOG2];
  assign w_ctrlMove       = i_pv_ctrl_in[UCI_WIDTH-1:0];
  assign w_unusedCtrl     = ^i_pv_ctrl_in;

  logic                   r_boardValid;
  logic                   r_clearEval;
  logic                   w_boardRise;
  logic                   w_clearRise;
  logic [NUM_PV-1:0]      w_hit;
  logic [NUM_PV-1:0]      w_consume;
  logic [NUM_PV_LOG2-1:0] w_firstLine;
  logic [NUM_PV-1:0]      r_mask;
  logic                   r_flag;
  logic [NUM_PV_LOG2-1:0] r_line;
  eval_state_t            r_state;
  eval_state_t            w_nextState;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_nextCount;

  assign w_boardRise = i_board_valid & ~r_boardValid;
  assign w_clearRise = i_clear_eval & ~r_clearEval;
  assign w_consume   = ((AUTO_CLEAR != 0) && w_clearRise) ? r_mask : '0;

  for (genvar g = 0; g < NUM_PV; g++) begin : g_line
    pv_line_store #(
      .UCI_WIDTH      (UCI_WIDTH),
      .MAX_DEPTH_LOG2 (MAX_DEPTH_LOG2)
    ) u_store (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_write       (w_ctrlWrite && (w_ctrlLine == NUM_PV_LOG2'(g))),
      .i_entry_valid (w_ctrlEntryValid),
      .i_wr_ply      (w_ctrlPly),
      .i_wr_move     (w_ctrlMove),
      .i_clear       (w_ctrlClearAll || (w_ctrlClearLine && (w_ctrlLine == NUM_PV_LOG2'(g)))),
      .i_consume     (w_consume[g]),
      .i_consume_ply (i_pv_ply),
      .i_rd_ply      (i_pv_ply),
      .i_rd_move     (i_uci_in),
      .o_hit         (w_hit[g])
    );
  end

  // Lowest-index hit wins; scanning downward lets the smallest index overwrite last.
  always_comb begin
    w_firstLine = '0;
    for (int i = NUM_PV - 1; i >= 0; i--) begin
      if (w_hit[i]) w_firstLine = NUM_PV_LOG2'(i);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_boardValid <= 1'b0;
      r_clearEval  <= 1'b0;
      r_mask       <= '0;
      r_flag       <= 1'b0;
      r_line       <= '0;
    end else begin
      r_boardValid <= i_board_valid;
      r_clearEval  <= i_clear_eval;
      if (w_boardRise) begin
        r_mask <= w_hit;
        r_flag <= |w_hit;
        r_line <= w_firstLine;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // A new board rise always restarts the wait, whatever state the FSM is in.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    case (r_state)
      ST_IDLE: w_nextState = ST_IDLE;
      ST_WAIT: begin
        if (r_count == '0) w_nextState = ST_DONE;
        else               w_nextCount = r_count - CNT_W'(1);
      end
      ST_DONE: if (w_clearRise) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
    if (w_boardRise) begin
      w_nextState = ST_WAIT;
      w_nextCount = CNT_W'(LATENCY_COUNT - 1);
    end
  end

  assign o_eval_pv_flag = r_flag;
  assign o_eval_pv_line = r_line;
  assign o_eval_pv_mask = r_mask;
  assign o_eval_valid   = (r_state == ST_DONE);

endmodule
